// File: rtl/mode_counter.sv
// mode_counter: parametrised up/down counter producing binary, Gray or
// Johnson sequences from one runtime-selectable instance, with parallel load,
// a combinational terminal-count flag and a registered wrap pulse.
// Optional feature: define MODE_COUNTER_SAT_EN to add the `sat` input, which
// makes the counter hold at its terminal count instead of wrapping.
module mode_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MODE_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;

  localparam logic [WIDTH-1:0] ZERO      = '0;
  localparam logic [WIDTH-1:0] JOHN_LAST = {1'b1, {(WIDTH-1){1'b0}}};

  // state_q is the binary index in binary/Gray modes and the shift register
  // itself in Johnson mode; mode_q records which of the two it currently is.
  logic [WIDTH-1:0] state_q, state_d;
  logic [1:0]       mode_q;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] gray_idx;
  logic [5:0]       trans_cnt;
  logic             john_legal;
  logic [WIDTH-1:0] load_state;
  logic [WIDTH-1:0] step_val;
  logic             john_cur;
  logic             tc_int;
  logic             sat_hold;
  logic             step;

  assign john_cur = (mode_q == MODE_JOHN);

  // Gray-decode the load value into a binary index, MSB downwards.
  always_comb begin
    gray_idx = '0;
    gray_idx[WIDTH-1] = load_val[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      gray_idx[i] = gray_idx[i+1] ^ load_val[i];
    end
  end

  // A legal Johnson code has at most one adjacent-bit transition.
  always_comb begin
    trans_cnt = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans_cnt = trans_cnt + 6'(load_val[i] ^ load_val[i+1]);
    end
  end

  assign john_legal = (trans_cnt <= 6'd1);

  // Load decoding follows the incoming mode so a load can accompany a mode switch.
  always_comb begin
    load_state = load_val;
    if (mode == MODE_JOHN) begin
      load_state = john_legal ? load_val : ZERO;
    end else if (mode == MODE_GRAY) begin
      load_state = gray_idx;
    end
  end

  // Terminal count: last state before wrapping in the current direction.
  always_comb begin
    tc_int = 1'b0;
    if (up) begin
      tc_int = john_cur ? (state_q == JOHN_LAST) : (&state_q);
    end else begin
      tc_int = (state_q == ZERO);
    end
  end

  // One step of the active sequence; Johnson down is the exact reverse shift.
  always_comb begin
    step_val = state_q;
    if (john_cur) begin
      if (up) begin
        step_val = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
      end else begin
        step_val = {~state_q[0], state_q[WIDTH-1:1]};
      end
    end else begin
      step_val = up ? (state_q + 1'b1) : (state_q - 1'b1);
    end
  end

`ifdef MODE_COUNTER_SAT_EN
  assign sat_hold = sat & tc_int;
`else
  assign sat_hold = 1'b0;
`endif

  assign step = en && (mode == mode_q) && !sat_hold;

  // Next-state priority: load, then mode-change clear, then step, else hold.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    if (load) begin
      state_d = load_state;
    end else if (mode != mode_q) begin
      state_d = ZERO;
    end else if (step) begin
      state_d = step_val;
      wrap_d  = tc_int;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      mode_q  <= MODE_BIN;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = (mode_q == MODE_GRAY) ? (state_q ^ (state_q >> 1)) : state_q;
  assign tc   = tc_int;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed scenarios plus randomized traffic for mode_counter
// (WIDTH=4), checked against a position-based reference model. Scenarios for
// the saturate feature are compiled in when MODE_COUNTER_SAT_EN is defined.
module tb_mode_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic         sat;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: registered mode plus position within that mode's cycle.
  logic [1:0] m_mode;
  int         m_pos;
  logic       m_wrap;

  mode_counter #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .up(up),
    .mode(mode),
    .load(load),
    .load_val(load_val),
`ifdef MODE_COUNTER_SAT_EN
    .sat(sat),
`endif
    .q(q),
    .tc(tc),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_period(logic [1:0] md);
    return (md == 2'b10) ? 2 * W : (1 << W);
  endfunction

  // Code word shown on q for a given position in the mode's sequence.
  function automatic logic [W-1:0] m_code(logic [1:0] md, int pos);
    if (md == 2'b10) begin
      if (pos <= W) return W'((1 << pos) - 1);
      return W'(((1 << (2 * W - pos)) - 1) << (pos - W));
    end else if (md == 2'b01) begin
      return W'(pos ^ (pos >> 1));
    end
    return W'(pos);
  endfunction

  function automatic logic m_tc(logic dir);
    return dir ? (m_pos == m_period(m_mode) - 1) : (m_pos == 0);
  endfunction

  task automatic model_reset();
    m_mode = 2'b00;
    m_pos  = 0;
    m_wrap = 1'b0;
  endtask

  // Advance one clock and the model alongside it; leaves time at the negedge.
  task automatic tick();
    int p;
    int per;
    @(posedge clk);
    m_wrap = 1'b0;
    if (load) begin
      p = 0;
      for (int k = 0; k < m_period(mode); k++) begin
        if (m_code(mode, k) == load_val) p = k;
      end
      m_pos = p;
    end else if (mode != m_mode) begin
      m_pos = 0;
    end else if (en && !(sat && m_tc(up))) begin
      per = m_period(m_mode);
      m_wrap = m_tc(up);
      m_pos = up ? (m_pos + 1) % per : (m_pos + per - 1) % per;
    end
    m_mode = mode;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; up = 1'b0; mode = 2'b00; load = 1'b0; load_val = '0; sat = 1'b0;
    model_reset();
    #2;
    checks++; if (q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_q: got %b expected 0000", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrap); end
    checks++; if (tc !== 1'b1) begin errors++; $display("[TB] FAIL reset_tc_down: got %b expected 1", tc); end
    up = 1'b1;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc_up: got %b expected 0", tc); end
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (q !== 4'b0101) begin errors++; $display("[TB] FAIL pre_reset_q: got %b expected 0101", q); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (q !== 4'b0000) begin errors++; $display("[TB] FAIL async_reset_q: got %b expected 0000", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_wrap: got %b expected 0", wrap); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (q !== 4'b0001) begin errors++; $display("[TB] FAIL resume_q: got %b expected 0001", q); end
    en = 1'b0;
  endtask

  task automatic test_binary();
    logic [W-1:0] exp;
    mode = 2'b00; load = 1'b1; load_val = '0; up = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = W'(i);
      checks++; if (q !== exp) begin errors++; $display("[TB] FAIL bin_up_q: got %b expected %b", q, exp); end
      checks++; if (tc !== (i == 15)) begin errors++; $display("[TB] FAIL bin_up_tc: step %0d got %b expected %b", i, tc, (i == 15)); end
      if (i < 15) tick();
    end
    tick();
    checks++; if (q !== 4'b0000 || wrap !== 1'b1) begin errors++; $display("[TB] FAIL bin_wrap: got q=%b wrap=%b expected q=0000 wrap=1", q, wrap); end
    tick();
    checks++; if (q !== 4'b0001 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL bin_wrap_pulse: got q=%b wrap=%b expected q=0001 wrap=0", q, wrap); end
    en = 1'b0; load = 1'b1; load_val = '0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    checks++; if (q !== 4'b1111 || wrap !== 1'b1) begin errors++; $display("[TB] FAIL bin_down_wrap: got q=%b wrap=%b expected q=1111 wrap=1", q, wrap); end
    en = 1'b0;
  endtask

  task automatic test_gray();
    logic [W-1:0] seq [5];
    seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    mode = 2'b01; en = 1'b0; up = 1'b1;
    tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (q !== seq[i]) begin errors++; $display("[TB] FAIL gray_q: step %0d got %b expected %b", i, q, seq[i]); end
      if (i < 4) tick();
    end
    en = 1'b0; load = 1'b1; load_val = 4'b1000;
    tick();
    load = 1'b0;
    checks++; if (q !== 4'b1000 || tc !== 1'b1) begin errors++; $display("[TB] FAIL gray_load_tc: got q=%b tc=%b expected q=1000 tc=1", q, tc); end
    en = 1'b1;
    tick();
    checks++; if (q !== 4'b0000 || wrap !== 1'b1) begin errors++; $display("[TB] FAIL gray_wrap: got q=%b wrap=%b expected q=0000 wrap=1", q, wrap); end
    en = 1'b0;
  endtask

  task automatic test_johnson();
    logic [W-1:0] seq [8];
    seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    mode = 2'b10; en = 1'b0; up = 1'b1;
    tick();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (q !== seq[i] || wrap !== (i == 7)) begin errors++; $display("[TB] FAIL john_up: step %0d got q=%b wrap=%b expected q=%b wrap=%b", i, q, wrap, seq[i], (i == 7)); end
    end
    up = 1'b0;
    tick();
    checks++; if (q !== 4'b1000) begin errors++; $display("[TB] FAIL john_down: got %b expected 1000", q); end
    en = 1'b0; load = 1'b1; load_val = 4'b0101;
    tick();
    checks++; if (q !== 4'b0000) begin errors++; $display("[TB] FAIL john_load_illegal: got %b expected 0000", q); end
    load_val = 4'b0111;
    tick();
    checks++; if (q !== 4'b0111) begin errors++; $display("[TB] FAIL john_load_legal: got %b expected 0111", q); end
    load = 1'b0;
  endtask

  task automatic test_mode_change();
    mode = 2'b00; en = 1'b0; load = 1'b1; load_val = 4'b0110;
    tick();
    tick();
    load = 1'b0;
    checks++; if (q !== 4'b0110) begin errors++; $display("[TB] FAIL mc_setup: got %b expected 0110", q); end
    mode = 2'b10;
    tick();
    checks++; if (q !== 4'b0000 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL mc_clear: got q=%b wrap=%b expected q=0000 wrap=0", q, wrap); end
    mode = 2'b00; load = 1'b1; load_val = 4'b0110;
    tick();
    mode = 2'b10; load_val = 4'b0011;
    tick();
    load = 1'b0;
    checks++; if (q !== 4'b0011) begin errors++; $display("[TB] FAIL mc_load_wins: got %b expected 0011", q); end
  endtask

`ifdef MODE_COUNTER_SAT_EN
  task automatic test_sat();
    sat = 1'b1; mode = 2'b00; en = 1'b0; load = 1'b1; load_val = 4'b1111;
    tick();
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    checks++; if (q !== 4'b1111 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL sat_bin_up: got q=%b wrap=%b expected q=1111 wrap=0", q, wrap); end
    en = 1'b0; load = 1'b1; load_val = 4'b0000;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    checks++; if (q !== 4'b0000 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL sat_down: got q=%b wrap=%b expected q=0000 wrap=0", q, wrap); end
    en = 1'b0; mode = 2'b10; load = 1'b1; load_val = 4'b1000;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    checks++; if (q !== 4'b1000 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL sat_john: got q=%b wrap=%b expected q=1000 wrap=0", q, wrap); end
    sat = 1'b0; en = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] exp_q;
    logic         exp_tc;
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 4) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
`ifdef MODE_COUNTER_SAT_EN
      sat = ($urandom_range(0, 7) == 0);
`endif
      tick();
      exp_q  = m_code(m_mode, m_pos);
      exp_tc = m_tc(up);
      checks++; if (q !== exp_q) begin errors++; $display("[TB] FAIL rand_q: cycle %0d got %b expected %b", i, q, exp_q); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("[TB] FAIL rand_wrap: cycle %0d got %b expected %b", i, wrap, m_wrap); end
      checks++; if (tc !== exp_tc) begin errors++; $display("[TB] FAIL rand_tc: cycle %0d got %b expected %b", i, tc, exp_tc); end
    end
    sat = 1'b0;
  endtask

  initial begin
    test_reset();
    test_binary();
    test_gray();
    test_johnson();
    test_mode_change();
`ifdef MODE_COUNTER_SAT_EN
    test_sat();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised multi-mode up/down counter; successor to the fixed 4-bit ripple, synchronous and Johnson up-counters. It provides binary, Gray and Johnson sequences from one runtime-selectable instance, with direction control, parallel load, a terminal-count flag and a wrap pulse. It is intended as the shared counting primitive for timers, sequencers and test stimulus throughout the design.

## Interface
- WIDTH, 4, width of `q` and `load_val`; legal range 2..32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable; advances state one step per cycle when high.
- up  in  1  direction: 1 = up, 0 = down.
- mode  in  2  sequence select: 00 binary, 01 Gray, 10 Johnson, 11 reserved (behaves as binary).
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value loaded when `load`=1, interpreted in the current mode's code.
- sat  in  1  saturate instead of wrap; port exists only with MODE_COUNTER_SAT_EN.
- q  out  WIDTH  registered count, in the current mode's code.
- tc  out  1  combinational terminal count: state is the last one before wrap in the current direction.
- wrap  out  1  registered one-cycle pulse, high in the cycle `q` first shows the wrapped value.

## Operation
- Binary/Gray state is held as a WIDTH-bit binary index `idx`.
  - Binary: `q = idx`.
  - Gray: `q = idx ^ (idx >> 1)`.
  - Steps are modulo 2^WIDTH.
- Johnson state is the WIDTH-bit shift register itself; the cycle is 2*WIDTH states.
  - Up: shift left, inserting `~q[WIDTH-1]` at bit 0 (0000→0001→0011→0111→1111→1110→1100→1000→0000).
  - Down: exact reverse of the up sequence.
- A registered copy `mode_q` of `mode` is kept.
- Per-edge priority, highest first:
  1. `load`=1:
     - Binary: `q <= load_val`.
     - Gray: `load_val` is Gray-decoded into `idx`.
     - Johnson: `load_val` is loaded if it is a legal Johnson code (at most one 0/1 transition across bits WIDTH-1..0); any illegal code loads 0.
  2. `mode != mode_q`: state cleared to 0, regardless of `en`.
  3. `en`=1: one step in direction `up`.
  4. Otherwise: hold.
- `mode_q <= mode` every edge.
- `tc` definition:
  - Up: `idx` all ones (binary/Gray) or `q` = 100..0 (Johnson).
  - Down: state all zeros (all modes).
- `wrap` is set on an edge where a step occurs with `tc`=1; otherwise it is cleared.
  - A `load` or mode-change clear never produces `wrap`.
- `up` may change on any cycle; the next step uses the new direction, and `tc` follows `up` combinationally.

## Timing
- Reset (`rst`=0, asynchronous, any time including mid-count):
  - `q`=0, `wrap`=0, `mode_q`=00.
  - `tc` follows its definition (1 if `up`=0, else 0).
- After `rst` rises, the first rising edge may step.
- `q` latency: 1 clock from `en`, `load` or mode change.
- `tc`: zero latency from `q`/`up`/`mode`.
- `wrap`: same edge as the wrapped `q`; high for exactly one cycle per wrap.
- Continuous `en` with `tc` recurring gives one `wrap` pulse per full period (2^WIDTH or 2*WIDTH cycles).
- Simultaneous `load` and mode change: the load wins, and `load_val` is decoded per the new `mode`.

## Configuration
- MODE_COUNTER_SAT_EN defined:
  - `sat` port present.
  - When `sat`=1, `en`=1 and `tc`=1, state holds and `wrap` stays 0, in all modes.
  - When `sat`=0, the counter wraps normally.
- Undefined: `sat` port absent; the counter always wraps.

## Test plan
All scenarios use WIDTH=4.
1. Reset: binary count at 0101, pull `rst` low between edges → `q`=0000 and `wrap`=0 immediately, without a clock edge; release → counting resumes from 0000.
2. Binary up: 16 `en` cycles from 0000 → `q` runs 0000..1111; `tc`=1 only at 1111; next edge gives `q`=0000 with `wrap`=1 for one cycle. Down from 0000 with `en` → 1111, `wrap`=1.
3. Gray up: from 0 → `q` runs 0000, 0001, 0011, 0010, 0110. Load 1000 → `tc`=1; next `en` edge → `q`=0000, `wrap`=1.
4. Johnson: up from 0000 → 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 (`wrap` at the last step). Down from 0000 → 1000. Load 0101 → `q`=0000; load 0111 → `q`=0111.
5. Mode change: binary at 0110, set `mode`=10 with `en`=0 → next edge `q`=0000, `wrap`=0. Same edge with `load`=1 and `load_val`=0011 → `q`=0011.
6. Built with MODE_COUNTER_SAT_EN:
   - `sat`=1, binary up at 1111 with `en` → `q` holds 1111, `wrap`=0.
   - Down at 0000 → holds 0000.
   - Johnson up at 1000 → holds 1000.
